// File: rtl/packed_word_buffer_if.sv
// Handshake bundle between the packing decoder, the elastic word buffer and the update stage.
// The buffer uses the slave modport; the producer/consumer side uses master.
interface packed_word_buffer_if #(
  parameter int no_of_units   = 4,
  parameter int element_width = 32,
  parameter int addr_width    = 2
);
  localparam int word_width = 2 * element_width * no_of_units;

  logic [word_width-1:0] in;
  logic                  write_now;
  logic [word_width-1:0] out;
  logic                  out_valid;
  logic                  out_ready;
  logic [addr_width:0]   count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [15:0]           words_accepted;

  modport master (
    output in, write_now, out_ready,
    input  out, out_valid, count, full, empty, overflow, words_accepted
  );

  modport slave (
    input  in, write_now, out_ready,
    output out, out_valid, count, full, empty, overflow, words_accepted
  );
endinterface

// File: rtl/packed_word_buffer.sv
// Elastic FIFO capturing each double-width packed word from the two-beat decoder
// and presenting it in order to the update stage over valid/ready.
module packed_word_buffer #(
  parameter int no_of_units   = 4,
  parameter int element_width = 32,
  parameter int depth         = 4,
  parameter int addr_width    = 2
) (
  input logic                clk,
  input logic                rst,
  packed_word_buffer_if.slave bus
);
  localparam int word_width = 2 * element_width * no_of_units;

  logic [word_width-1:0] r_mem [depth];
  logic [addr_width-1:0] r_wrPtr;
  logic [addr_width-1:0] r_rdPtr;
  logic [addr_width:0]   r_count;
  logic                  r_overflow;
  logic [15:0]           r_wordsAccepted;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Status comes from the registered count so write_now never reaches it combinationally.
  assign w_full  = (r_count == (addr_width+1)'(depth));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_push  = bus.write_now && (!w_full || w_pop);
  assign w_drop  = bus.write_now && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr         <= '0;
      r_rdPtr         <= '0;
      r_count         <= '0;
      r_overflow      <= 1'b0;
      r_wordsAccepted <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr         <= r_wrPtr + 1'b1;
        r_wordsAccepted <= r_wordsAccepted + 16'd1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wrPtr] <= bus.in;
    end
  end

  assign bus.out            = w_empty ? '0 : r_mem[r_rdPtr];
  assign bus.out_valid      = !w_empty;
  assign bus.count          = r_count;
  assign bus.full           = w_full;
  assign bus.empty          = w_empty;
  assign bus.overflow       = r_overflow;
  assign bus.words_accepted = r_wordsAccepted;
endmodule

// File: tb/tb_packed_word_buffer.sv
// Randomized scoreboard bench for packed_word_buffer: stimulus enqueues expected words,
// an independent negedge monitor pops and compares every word the DUT hands over.
module tb_packed_word_buffer;
  localparam int NU    = 4;
  localparam int EW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int W     = 2 * EW * NU;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  packed_word_buffer_if #(.no_of_units(NU), .element_width(EW), .addr_width(AW)) bus ();

  packed_word_buffer #(
    .no_of_units(NU), .element_width(EW), .depth(DEPTH), .addr_width(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [W-1:0] expQ [$];
  int           expAccepted;
  bit           expOverflow;
  int           testsRun    = 0;
  int           testsFailed = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] randWord();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Compare every status output against the model's queue occupancy.
  task automatic checkOutput();
    int occ;
    occ = expQ.size();
    check("count", W'(bus.count), W'(occ));
    check("full", W'(bus.full), W'(occ == DEPTH));
    check("empty", W'(bus.empty), W'(occ == 0));
    check("out_valid", W'(bus.out_valid), W'(occ != 0));
    check("out", bus.out, (occ != 0) ? expQ[0] : '0);
    check("overflow", W'(bus.overflow), W'(expOverflow));
    check("words_accepted", W'(bus.words_accepted), W'(expAccepted % 65536));
  endtask

  task automatic applyStimulus(input bit wn, input logic [W-1:0] word, input bit rdy);
    int occ;
    checkOutput();
    bus.write_now = wn;
    bus.in        = word;
    bus.out_ready = rdy;
    if (wn) begin
      occ = expQ.size();
      if (occ < DEPTH || (occ > 0 && rdy)) begin
        expQ.push_back(word);
        expAccepted++;
      end else begin
        expOverflow = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles, input bit wn, input bit rdy);
    rst           = 1'b1;
    bus.write_now = wn;
    bus.in        = randWord();
    bus.out_ready = rdy;
    expQ.delete();
    expAccepted = 0;
    expOverflow = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.write_now = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected pop: got %0h expected no word", bus.out);
      end else begin
        check("popped word", bus.out, expQ.pop_front());
      end
    end
  end

  initial begin
    logic [W-1:0] firstWord;
    bus.write_now = 1'b0;
    bus.out_ready = 1'b0;
    bus.in        = '0;

    for (int i = 0; i < 2 * NU; i++) firstWord[(2*NU-1-i)*32 +: 32] = 32'(i + 1);
    doReset(2, 1'b0, 1'b0);
    applyStimulus(1'b1, firstWord, 1'b0);
    checkOutput();

    // Fill, overflow, then drain.
    doReset(1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, randWord(), 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput();

    // Write into a full FIFO while popping.
    doReset(1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, randWord(), 1'b0);
    applyStimulus(1'b1, randWord(), 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput();

    // Decoder cadence across several pointer wraps.
    doReset(1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, randWord(), 1'b1);
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput();

    // Back-pressure hold.
    doReset(1, 1'b0, 1'b0);
    applyStimulus(1'b1, randWord(), 1'b0);
    applyStimulus(1'b1, randWord(), 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'($urandom_range(0, 1)));
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput();

    // Reset landing together with a write and a pop.
    doReset(1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randWord(), 1'b0);
    checkOutput();
    doReset(1, 1'b1, 1'b1);
    checkOutput();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), randWord(), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
